// File: rtl/ppm_pkg.sv
// Shared types and constants for the PPM frame decoder.
package ppm_pkg;

  // Decoder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOF  = 2'd1,
    DATA = 2'd2
  } ppm_state_t;

  // The start-of-frame marker always spans four slots.
  localparam int SOF_SLOTS = 4;

  // End-of-frame: lows in exactly these two slots of a data window.
  localparam int EOF_SLOT_A   = 0;
  localparam int EOF_SLOT_B   = 1;
  localparam int EOF_LOW_MASK = (1 << EOF_SLOT_A) | (1 << EOF_SLOT_B);

  // Width of a counter that runs 0..osr-1.
  function automatic int osr_cnt_w(input int osr);
    return (osr > 2) ? $clog2(osr) : 1;
  endfunction

endpackage

// File: rtl/ppm_slot_timer.sv
// Slot timing: oversampling counter, slot index, mid-slot sample strobe and
// window-end strobe. Parked at zero while clear is high.
module ppm_slot_timer
  import ppm_pkg::*;
#(
  parameter int OSR    = 16,
  parameter int SLOT_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [SLOT_W-1:0] win_last,
  output logic              sample_stb,
  output logic              win_end,
  output logic [SLOT_W-1:0] slot_idx
);

  localparam int               CNT_W     = osr_cnt_w(OSR);
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(OSR / 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OSR - 1);

  logic [CNT_W-1:0]  cnt_reg;
  logic [SLOT_W-1:0] slot_reg;
  logic              win_done_reg;

  assign sample_stb = ~clear && (cnt_reg == SAMPLE_AT);
  assign win_end    = sample_stb && (slot_reg == win_last);
  assign slot_idx   = slot_reg;

  // Count clocks within a slot; the slot index restarts at the wrap following a
  // window end, so SOF and data windows of different length chain seamlessly.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt_reg      <= '0;
      slot_reg     <= '0;
      win_done_reg <= 1'b0;
    end else begin
      if (win_end) begin
        win_done_reg <= 1'b1;
      end
      if (cnt_reg == CNT_LAST) begin
        cnt_reg      <= '0;
        slot_reg     <= win_done_reg ? '0 : slot_reg + SLOT_W'(1);
        win_done_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ppm_decoder_gen.sv
// PPM frame decoder: synchronizes the line, detects SOF, decodes one symbol per
// window into LSB-first bytes and terminates frames on EOF or malformed windows.
module ppm_decoder_gen
  import ppm_pkg::*;
#(
  parameter int         OSR      = 16,
  parameter int         PPM_BITS = 2,
  parameter int         BYTE_W   = 8,
  parameter logic [3:0] SOF_PAT  = 4'b0110
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Din,
  output logic [BYTE_W-1:0] Dout,
  output logic              D_en,
  output logic              F_en,
  output logic              err,
  output logic [7:0]        byte_cnt
);

  localparam int NSLOT  = 1 << PPM_BITS;
  localparam int SPB    = BYTE_W / PPM_BITS;
  localparam int SLOT_W = (PPM_BITS > 2) ? PPM_BITS : 2;
  localparam int SYM_W  = (SPB > 1) ? $clog2(SPB) : 1;

  localparam logic [NSLOT-1:0]  EOF_MASK  = NSLOT'(EOF_LOW_MASK);
  localparam logic [SLOT_W-1:0] SOF_LAST  = SLOT_W'(SOF_SLOTS - 1);
  localparam logic [SLOT_W-1:0] DATA_LAST = SLOT_W'(NSLOT - 1);
  localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(SPB - 1);

  generate
    if ((PPM_BITS < 1) || (PPM_BITS > 3) || ((BYTE_W % PPM_BITS) != 0) ||
        (OSR < 4) || ((OSR % 2) != 0)) begin : g_bad_params
      $error("ppm_decoder_gen: unsupported OSR/PPM_BITS/BYTE_W combination");
    end
  endgenerate

  logic              sync_meta_reg, ds_reg, ds_prev_reg;
  logic              ds_fall;
  logic              sample_stb, win_end;
  logic [SLOT_W-1:0] slot_idx, win_last;

  ppm_state_t        state_reg, state_next;
  logic [NSLOT-1:0]  low_mask_reg, low_mask_next, low_mask_now;
  logic [BYTE_W-1:0] shift_reg, shift_next, shift_in;
  logic [BYTE_W-1:0] dout_reg, dout_next;
  logic [SYM_W-1:0]  sym_cnt_reg, sym_cnt_next;
  logic [7:0]        byte_cnt_reg, byte_cnt_next;
  logic              d_en_reg, d_en_next, f_en_reg, f_en_next, err_reg, err_next;
  logic [PPM_BITS-1:0] sym_val;
  logic              one_low, is_eof;

  // Two-flop synchronizer for the asynchronous line, plus a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta_reg <= 1'b1;
      ds_reg        <= 1'b1;
      ds_prev_reg   <= 1'b1;
    end else begin
      sync_meta_reg <= Din;
      ds_reg        <= sync_meta_reg;
      ds_prev_reg   <= ds_reg;
    end
  end

  assign ds_fall  = ds_prev_reg & ~ds_reg;
  assign win_last = (state_reg == SOF) ? SOF_LAST : DATA_LAST;

  ppm_slot_timer #(
    .OSR    (OSR),
    .SLOT_W (SLOT_W)
  ) u_slot_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state_reg == IDLE),
    .win_last   (win_last),
    .sample_stb (sample_stb),
    .win_end    (win_end),
    .slot_idx   (slot_idx)
  );

  // Low-slot map of the current window including the sample being taken now.
  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_low_mask
      assign low_mask_now[gi] = low_mask_reg[gi] | (~ds_reg & (slot_idx == SLOT_W'(gi)));
    end
  endgenerate

  // Symbol value is the position of the (single) low slot.
  always_comb begin
    sym_val = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (low_mask_now[i]) begin
        sym_val = PPM_BITS'(i);
      end
    end
  end

  assign one_low = ($countones(low_mask_now) == 1);
  assign is_eof  = (low_mask_now == EOF_MASK);

  // New symbols enter at the top, so the first symbol ends up in the lowest bits.
  generate
    if (SPB == 1) begin : g_shift_single
      assign shift_in = sym_val;
    end else begin : g_shift_multi
      assign shift_in = {sym_val, shift_reg[BYTE_W-1:PPM_BITS]};
    end
  endgenerate

  // Next-state and output decisions; windows are only judged at their final sample.
  always_comb begin
    state_next    = state_reg;
    low_mask_next = low_mask_reg;
    shift_next    = shift_reg;
    dout_next     = dout_reg;
    sym_cnt_next  = sym_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    f_en_next     = f_en_reg;
    d_en_next     = 1'b0;
    err_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        low_mask_next = '0;
        if (ds_fall) begin
          state_next = SOF;
        end
      end
      SOF: begin
        if (sample_stb) begin
          if (ds_reg != SOF_PAT[slot_idx[1:0]]) begin
            state_next = IDLE;
          end else if (win_end) begin
            state_next    = DATA;
            f_en_next     = 1'b1;
            byte_cnt_next = '0;
            sym_cnt_next  = '0;
            low_mask_next = '0;
          end
        end
      end
      DATA: begin
        if (sample_stb) begin
          if (!win_end) begin
            low_mask_next = low_mask_now;
          end else begin
            low_mask_next = '0;
            if (is_eof) begin
              // EOF is checked first so that with one bit per symbol it wins over decoding.
              state_next   = IDLE;
              f_en_next    = 1'b0;
              err_next     = (sym_cnt_reg != '0);
              sym_cnt_next = '0;
            end else if (one_low) begin
              if (sym_cnt_reg == SYM_LAST) begin
                dout_next     = shift_in;
                d_en_next     = 1'b1;
                sym_cnt_next  = '0;
                byte_cnt_next = (byte_cnt_reg == 8'hFF) ? byte_cnt_reg : byte_cnt_reg + 8'd1;
              end else begin
                shift_next   = shift_in;
                sym_cnt_next = sym_cnt_reg + SYM_W'(1);
              end
            end else begin
              state_next   = IDLE;
              f_en_next    = 1'b0;
              err_next     = 1'b1;
              sym_cnt_next = '0;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      low_mask_reg <= '0;
      shift_reg    <= '0;
      dout_reg     <= '0;
      sym_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      d_en_reg     <= 1'b0;
      f_en_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      low_mask_reg <= low_mask_next;
      shift_reg    <= shift_next;
      dout_reg     <= dout_next;
      sym_cnt_reg  <= sym_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      d_en_reg     <= d_en_next;
      f_en_reg     <= f_en_next;
      err_reg      <= err_next;
    end
  end

  assign Dout     = dout_reg;
  assign D_en     = d_en_reg;
  assign F_en     = f_en_reg;
  assign err      = err_reg;
  assign byte_cnt = byte_cnt_reg;

endmodule

// File: tb/tb_ppm_decoder_gen.sv
// Self-checking bench for ppm_decoder_gen (OSR=16, PPM_BITS=2, BYTE_W=8).
module tb_ppm_decoder_gen;

  localparam int         OSR        = 16;
  localparam int         CLK_T      = 10;
  localparam int         SLOT_T     = OSR * CLK_T;
  localparam logic [3:0] SOF_LEVELS = 4'b0110;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       Din   = 1'b1;
  logic [7:0] Dout;
  logic       D_en, F_en, err;
  logic [7:0] byte_cnt;

  int total = 0;
  int bad   = 0;

  always #(CLK_T / 2) clk = ~clk;

  ppm_decoder_gen #(
    .OSR      (OSR),
    .PPM_BITS (2),
    .BYTE_W   (8),
    .SOF_PAT  (4'b0110)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Din      (Din),
    .Dout     (Dout),
    .D_en     (D_en),
    .F_en     (F_en),
    .err      (err),
    .byte_cnt (byte_cnt)
  );

  // Output monitor: sole writer of the event logs below.
  logic [7:0] got_q[$];
  time        got_t_q[$];
  int         err_seen = 0;
  time        err_t    = 0;
  int         fen_cyc  = 0;
  int         dup      = 0;
  logic       d_en_d   = 1'b0;
  logic       err_d    = 1'b0;

  always @(negedge clk) begin
    if (D_en) begin
      got_q.push_back(Dout);
      got_t_q.push_back($time);
    end
    if (err) begin
      err_seen++;
      err_t = $time;
    end
    if (F_en) fen_cyc++;
    if ((D_en && d_en_d) || (err && err_d)) dup++;
    d_en_d = D_en;
    err_d  = err;
  end

  typedef struct {
    int          nwin;     // windows after SOF, in send order
    logic [63:0] w;        // one low-mask nibble per window, first window leftmost
    int          nbytes;
    logic [15:0] bytes;    // [7:0] first byte, [15:8] second byte
    int          exp_err;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t       tbl[7];
  logic [3:0] win_q[$];
  logic [7:0] exp_q[$];
  time        t_start;
  logic [3:0] sof_lv;
  logic [7:0] model_dout;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_win(input string nm, input time t, input time lo, input time hi);
    total++;
    if (t < lo || t > hi) begin
      bad++;
      $display("FAIL %s: event at %0t, want within %0t..%0t", nm, t, lo, hi);
    end
  endtask

  task automatic send_slot(input logic lvl);
    Din = lvl;
    repeat (OSR) @(negedge clk);
  endtask

  task automatic send_sof();
    t_start = $time;
    for (int s = 0; s < 4; s++) send_slot(sof_lv[s]);
  endtask

  task automatic send_window(input logic [3:0] lows);
    for (int s = 0; s < 4; s++) send_slot(~lows[s]);
  endtask

  // Sends SOF + win_q, then checks the outcome against exp_q / exp_err / exp_dout.
  task automatic run_frame(input string tag, input int exp_err, input logic [7:0] exp_dout);
    int  q0, e0, ng, last_slot;
    q0 = got_q.size();
    e0 = err_seen;
    send_slot(1'b1);
    send_slot(1'b1);
    send_sof();
    check({tag, " F_en in frame"}, F_en, 1);
    foreach (win_q[i]) send_window(win_q[i]);
    for (int i = 0; i < 3; i++) send_slot(1'b1);
    ng = got_q.size() - q0;
    check({tag, " D_en count"}, ng, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < ng) check($sformatf("%s byte%0d", tag, i), got_q[q0 + i], exp_q[i]);
    end
    if (exp_q.size() > 0 && ng > 0)
      check_win({tag, " D_en timing"}, got_t_q[q0], t_start + 19 * SLOT_T,
                t_start + 20 * SLOT_T + 4 * CLK_T);
    check({tag, " err count"}, err_seen - e0, exp_err);
    if (exp_err > 0 && err_seen > e0) begin
      last_slot = 4 + 4 * win_q.size() - 1;
      check_win({tag, " err timing"}, err_t, t_start + last_slot * SLOT_T,
                t_start + (last_slot + 1) * SLOT_T + 4 * CLK_T);
    end
    check({tag, " Dout"}, Dout, exp_dout);
    check({tag, " byte_cnt"}, byte_cnt, exp_q.size());
    check({tag, " F_en after"}, F_en, 0);
    $display("%s: windows=%0d bytes=%0d/%0d err=%0d/%0d Dout=%02h byte_cnt=%0d",
             tag, win_q.size(), ng, exp_q.size(), err_seen - e0, exp_err, Dout, byte_cnt);
  endtask

  // Reference: classify each window, collect symbols, group four per byte.
  task automatic model_frame(output int m_err);
    int syms[$];
    int b;
    m_err = 0;
    exp_q.delete();
    foreach (win_q[i]) begin
      if (win_q[i] == 4'b0011) begin
        m_err = ((syms.size() % 4) != 0) ? 1 : 0;
        break;
      end else if ($countones(win_q[i]) == 1) begin
        for (int j = 0; j < 4; j++) if (win_q[i][j]) syms.push_back(j);
      end else begin
        m_err = 1;
        break;
      end
    end
    for (int k = 0; k + 3 < syms.size(); k += 4) begin
      b = syms[k] + 4 * syms[k + 1] + 16 * syms[k + 2] + 64 * syms[k + 3];
      exp_q.push_back(8'(b));
    end
  endtask

  initial begin
    int         nsym, bad_pos, m_err, q0, e0, f0;
    logic [3:0] m;
    vec_t       r;

    sof_lv = SOF_LEVELS;
    //           nwin  windows              nbytes bytes     err dout
    tbl[0] = '{5, 64'h22443,      1, 16'h00A5, 0, 8'hA5};
    tbl[1] = '{9, 64'h111188883,  2, 16'hFF00, 0, 8'hFF};
    tbl[2] = '{1, 64'hA,          0, 16'h0000, 1, 8'hFF};
    tbl[3] = '{3, 64'h813,        0, 16'h0000, 1, 8'hFF};
    tbl[4] = '{5, 64'h84210,      1, 16'h001B, 1, 8'h1B};
    tbl[5] = '{1, 64'h7,          0, 16'h0000, 1, 8'h1B};
    tbl[6] = '{1, 64'h3,          0, 16'h0000, 0, 8'h1B};

    // Reset state.
    rst_n = 1'b0;
    Din   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset Dout", Dout, 0);
    check("reset D_en", D_en, 0);
    check("reset F_en", F_en, 0);
    check("reset err", err, 0);
    check("reset byte_cnt", byte_cnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed frame table.
    for (int t = 0; t < 7; t++) begin
      r = tbl[t];
      win_q.delete();
      exp_q.delete();
      for (int i = 0; i < r.nwin; i++) win_q.push_back(r.w[4 * (r.nwin - 1 - i) +: 4]);
      if (r.nbytes > 0) exp_q.push_back(r.bytes[7:0]);
      if (r.nbytes > 1) exp_q.push_back(r.bytes[15:8]);
      run_frame($sformatf("row%0d", t), r.exp_err, r.exp_dout);
    end

    // SOF mismatch: low, low instead of low, high -> silent return to idle.
    q0 = got_q.size();
    e0 = err_seen;
    f0 = fen_cyc;
    send_slot(1'b1);
    send_slot(1'b0);
    send_slot(1'b0);
    for (int i = 0; i < 6; i++) send_slot(1'b1);
    check("sof_mismatch F_en cycles", fen_cyc - f0, 0);
    check("sof_mismatch err count", err_seen - e0, 0);
    check("sof_mismatch D_en count", got_q.size() - q0, 0);
    $display("sof_mismatch: F_en cycles=%0d err=%0d", fen_cyc - f0, err_seen - e0);

    // Reset in the middle of a byte, then a clean frame.
    send_slot(1'b1);
    send_sof();
    send_window(4'h2);
    send_window(4'h4);
    Din   = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset Dout", Dout, 0);
    check("midreset D_en", D_en, 0);
    check("midreset F_en", F_en, 0);
    check("midreset err", err, 0);
    check("midreset byte_cnt", byte_cnt, 0);
    rst_n = 1'b1;
    e0 = err_seen;
    q0 = got_q.size();
    send_slot(1'b1);
    check("midreset no err", err_seen - e0, 0);
    check("midreset no D_en", got_q.size() - q0, 0);
    $display("midreset: outputs after reset Dout=%02h F_en=%0b byte_cnt=%0d", Dout, F_en, byte_cnt);
    win_q = '{4'h1, 4'h8, 4'h8, 4'h1, 4'h3};
    exp_q = '{8'h3C};
    run_frame("after_reset", 0, 8'h3C);
    model_dout = 8'h3C;

    // Randomized frames against the reference model.
    for (int f = 0; f < 25; f++) begin
      win_q.delete();
      nsym    = $urandom_range(0, 12);
      bad_pos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nsym)) : -1;
      for (int i = 0; i <= nsym; i++) begin
        if (i == bad_pos) begin
          do m = 4'($urandom_range(0, 15)); while ($countones(m) == 1 || m == 4'b0011);
          win_q.push_back(m);
          break;
        end
        if (i == nsym) begin
          win_q.push_back(4'b0011);
        end else begin
          m = 4'b0001 << $urandom_range(0, 3);
          win_q.push_back(m);
        end
      end
      model_frame(m_err);
      if (exp_q.size() > 0) model_dout = exp_q[exp_q.size() - 1];
      run_frame($sformatf("rand%0d", f), m_err, model_dout);
    end

    check("strobe single-cycle violations", dup, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
